// File: rtl/serial_alu_pkg.sv
// Shared types for the digit-serial ALU sequencer: op codes, sequencer states
// and the effective fill helper used for word2 digits above the valid width.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } AluOp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } SeqState;

    // Fill bit as seen by the adder: SUB inverts word2, so its fill flips too.
    function automatic logic fill_digit(input logic neg, input logic is_sub);
        return neg ^ is_sub;
    endfunction

endpackage

// File: rtl/digit_alu.sv
// One-digit combinational ALU; b is already inverted by the caller for SUB.
module digit_alu
    import serial_alu_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               carry_in,
    input  AluOp               op,
    output logic [DIGIT_W-1:0] r,
    output logic               carry_out
);

    logic [DIGIT_W:0] sum;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, carry_in};
        r         = sum[DIGIT_W-1:0];
        carry_out = sum[DIGIT_W];
        case (op)
            ALU_AND: begin r = a & b; carry_out = 1'b0; end
            ALU_OR:  begin r = a | b; carry_out = 1'b0; end
            ALU_XOR: begin r = a ^ b; carry_out = 1'b0; end
            default: ;  // ADD, SUB and reserved codes use the adder
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Digit-serial ALU sequencer: one DIGIT_W digit per clock, start/busy/done
// handshake, word2 fill above last_digit_idx and early exit for ADD/SUB.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int DIGIT_W = 4,
    localparam int NDIGITS = XLEN / DIGIT_W,
    localparam int IDX_W   = $clog2(NDIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  AluOp             op,
    input  logic [IDX_W-1:0] last_digit_idx,
    input  logic             word2_is_negative,
    input  logic [XLEN-1:0]  word1,
    input  logic [XLEN-1:0]  word2,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic             carry_out
);

    SeqState          state;
    AluOp             op_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] idx;
    logic             neg_q;
    logic             carry;
    logic [XLEN-1:0]  w2_q;

    logic               is_sub;
    logic               is_arith;
    logic               fill_eff;
    logic               early;
    logic               final_dig;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] r_dig;
    logic               c_dig;

    always_comb begin
        is_sub   = (op_q == ALU_SUB);
        is_arith = !(op_q inside {ALU_AND, ALU_OR, ALU_XOR});
        fill_eff = fill_digit(neg_q, is_sub);
        a_dig    = result[idx*DIGIT_W +: DIGIT_W];
        b_dig    = (idx <= last_q) ? w2_q[idx*DIGIT_W +: DIGIT_W] : {DIGIT_W{neg_q}};
        if (is_sub)
            b_dig = ~b_dig;
        // Past the valid word2 digits, a carry matching the fill leaves the
        // upper word1 digits already in result unchanged.
        early     = is_arith && (idx >= last_q) && (c_dig == fill_eff);
        final_dig = early || (idx == IDX_W'(NDIGITS - 1));
    end

    digit_alu #(.DIGIT_W(DIGIT_W)) u_digit (
        .a         (a_dig),
        .b         (b_dig),
        .carry_in  (carry),
        .op        (op_q),
        .r         (r_dig),
        .carry_out (c_dig)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= ALU_ADD;
            last_q    <= '0;
            idx       <= '0;
            neg_q     <= 1'b0;
            carry     <= 1'b0;
            w2_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    result[idx*DIGIT_W +: DIGIT_W] <= r_dig;
                    carry <= c_dig;
                    if (final_dig) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        carry_out <= c_dig;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin  // IDLE and DONE accept a new request
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        op_q   <= op;
                        last_q <= last_digit_idx;
                        neg_q  <= word2_is_negative;
                        w2_q   <= word2;
                        result <= word1;
                        idx    <= '0;
                        carry  <= (op == ALU_SUB);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq at 32/4 and 16/8 geometries.
module tb_serial_alu_seq;
    import serial_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    AluOp        op = ALU_ADD;
    logic [2:0]  last = '0;
    logic        neg = 1'b0;
    logic [31:0] word1 = '0;
    logic [31:0] word2 = '0;
    logic        busy, done, carry_out;
    logic [31:0] result;

    logic        s_start = 1'b0;
    AluOp        s_op = ALU_ADD;
    logic [0:0]  s_last = '0;
    logic        s_neg = 1'b0;
    logic [15:0] s_word1 = '0;
    logic [15:0] s_word2 = '0;
    logic        s_busy, s_done, s_carry_out;
    logic [15:0] s_result;

    int n_chk = 0;
    int n_fail = 0;
    int cyc, bcnt;

    always #5 clk = ~clk;

    serial_alu_seq #(.XLEN(32), .DIGIT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .last_digit_idx(last),
        .word2_is_negative(neg), .word1(word1), .word2(word2),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out)
    );

    serial_alu_seq #(.XLEN(16), .DIGIT_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(s_start), .op(s_op), .last_digit_idx(s_last),
        .word2_is_negative(s_neg), .word1(s_word1), .word2(s_word2),
        .busy(s_busy), .done(s_done), .result(s_result), .carry_out(s_carry_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request in the current cycle; it is taken at the next edge.
    task automatic drive(input AluOp o, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] l, input logic n);
        op = o; word1 = a; word2 = b; last = l; neg = n; start = 1'b1;
    endtask

    task automatic launch(input AluOp o, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] l, input logic n);
        @(posedge clk); #1;
        drive(o, a, b, l, n);
    endtask

    // cyc counts cycles with the start cycle as 0; poke fires a start in RUN.
    task automatic wait_done(input bit poke, output int c, output int bc);
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; bc = 0;
        while (!done && c < 40) begin
            if (busy) bc++;
            if (poke && c == 3) begin
                start = 1'b1; op = ALU_XOR; word1 = 32'hFFFF_FFFF;
            end else if (poke && c == 4) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_carry", {63'd0, carry_out}, 64'd0);
        #20 rst = 1'b0;

        // ADD with short positive immediate: 0xFF + 0x4
        launch(ALU_ADD, 32'h0000_00FF, 32'h4, 3'd0, 1'b0);
        wait_done(1'b0, cyc, bcnt);
        check("c1_result", {32'd0, result}, 64'h103);
        check("c1_carry", {63'd0, carry_out}, 64'd0);
        check("c1_latency", 64'(cyc), 64'd4);
        check("c1_busy", 64'(bcnt), 64'd3);
        @(posedge clk); #1;
        check("c1_done_pulse", {63'd0, done}, 64'd0);
        check("c1_hold", {32'd0, result}, 64'h103);

        // ADD with negative 12-bit immediate: early exit after digit 2
        launch(ALU_ADD, 32'h7B, 32'hFFE, 3'd2, 1'b1);
        wait_done(1'b0, cyc, bcnt);
        check("c2_result", {32'd0, result}, 64'h79);
        check("c2_carry", {63'd0, carry_out}, 64'd1);
        check("c2_latency", 64'(cyc), 64'd4);

        // SUB full word, with a start pulse in RUN that must be ignored
        launch(ALU_SUB, 32'd5, 32'd7, 3'd7, 1'b0);
        wait_done(1'b1, cyc, bcnt);
        check("c3_result", {32'd0, result}, 64'hFFFF_FFFE);
        check("c3_carry", {63'd0, carry_out}, 64'd0);
        check("c3_latency", 64'(cyc), 64'd9);
        check("c3_busy", 64'(bcnt), 64'd8);

        // XOR with garbage above the valid word2 digits, negative fill
        launch(ALU_XOR, 32'hA5A5_A5A5, 32'h1234_FFFF, 3'd3, 1'b1);
        wait_done(1'b0, cyc, bcnt);
        check("c4_result", {32'd0, result}, 64'h5A5A_5A5A);
        check("c4_carry", {63'd0, carry_out}, 64'd0);
        check("c4_latency", 64'(cyc), 64'd9);

        // Async reset during digit 2 of the SUB
        launch(ALU_SUB, 32'd5, 32'd7, 3'd7, 1'b0);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("mid_busy_pre", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_busy", {63'd0, busy}, 64'd0);
        check("mid_done", {63'd0, done}, 64'd0);
        check("mid_result", {32'd0, result}, 64'd0);
        check("mid_carry", {63'd0, carry_out}, 64'd0);
        #3 rst = 1'b0;
        launch(ALU_ADD, 32'h0000_00FF, 32'h4, 3'd0, 1'b0);
        wait_done(1'b0, cyc, bcnt);
        check("c5_result", {32'd0, result}, 64'h103);

        // start held in DONE chains straight into the next operation
        drive(ALU_ADD, 32'h7B, 32'hFFE, 3'd2, 1'b1);
        wait_done(1'b0, cyc, bcnt);
        check("chain_result", {32'd0, result}, 64'h79);
        check("chain_latency", 64'(cyc), 64'd4);
        check("chain_busy", 64'(bcnt), 64'd3);

        // Reserved op code behaves as ADD; one digit gives minimum latency
        launch(AluOp'(3'd7), 32'd1, 32'd1, 3'd0, 1'b0);
        wait_done(1'b0, cyc, bcnt);
        check("rsv_result", {32'd0, result}, 64'd2);
        check("rsv_latency", 64'(cyc), 64'd2);

        // 16-bit byte-serial instance: 0x00FF + 0x01
        @(posedge clk); #1;
        s_op = ALU_ADD; s_word1 = 16'h00FF; s_word2 = 16'h0001; s_last = 1'b0;
        s_neg = 1'b0; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 1;
        while (!s_done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b16_done", {63'd0, s_done}, 64'd1);
        check("b16_result", {48'd0, s_result}, 64'h0100);
        check("b16_carry", {63'd0, s_carry_out}, 64'd0);
        check("b16_latency", 64'(cyc), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
Digit-serial ALU sequencer for the multicycle RV32 core. It is the parametrised successor of the nibble-loop ALU that the control FSM drives. It processes one DIGIT_W-bit digit per clock over an XLEN-bit word and supports ADD/SUB/AND/OR/XOR. It sign- or zero-fills a short word2 operand, such as a 12-bit immediate, and ends ADD/SUB early once the remaining digits cannot change. The control FSM starts it with a start/busy/done handshake and uses it for PC increment, OP_IMM, OP and load/store address calculation.

Parameters:
XLEN, 32, operand/result width in bits; XLEN % DIGIT_W == 0 required.
DIGIT_W, 4, bits processed per cycle (4 = nibble, 8 = byte).
NDIGITS, XLEN/DIGIT_W (localparam), digit count; must be a power of 2 and >= 2.
IDX_W, $clog2(NDIGITS) (localparam), digit index width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  request; sampled only in IDLE or DONE.
op  in  AluOp (3)  operation, sampled with start.
last_digit_idx  in  IDX_W  index of the most significant valid word2 digit (0 = 4-bit width, 2 = 12-bit imm, 7 = full word at defaults).
word2_is_negative  in  1  selects fill for word2 digits above last_digit_idx (1 = all ones, 0 = zeros).
word1  in  XLEN  operand A, sampled with start.
word2  in  XLEN  operand B, sampled with start; bits above the valid digits are ignored.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse; result and carry_out are valid from this cycle.
result  out  XLEN  result register.
carry_out  out  1  final carry for ADD/SUB (SUB: 1 = no borrow); 0 for logic ops.

Behaviour:
- Reset (async, any state, including mid-operation): state = IDLE, busy = 0, done = 0, result = 0, carry_out = 0, index = 0.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - IDLE or DONE with start = 1 goes to RUN.
  - On that edge, latch op, last_digit_idx, fill, word1 and word2; load result <= word1; set index = 0; set carry = 1 for SUB, 0 otherwise.
- RUN, one digit i per cycle:
  - b = word2 digit i if i <= last, else the fill digit.
  - b' = ~b for SUB, b otherwise.
  - Digit result r = op(a_i, b', carry); write it into result digit i; update carry.
- RUN exit:
  - Leave to DONE after i == NDIGITS-1.
  - Leave early (ADD/SUB only) when i >= last and the effective fill f' (fill inverted for SUB) and carry out satisfy (f' = 0 and c = 0) or (f' = all-ones and c = 1). The remaining result digits then already equal the word1 digits held in result.
  - Otherwise i += 1.
- carry_out is written on the RUN->DONE edge. On an early exit it equals c, which would propagate unchanged to bit XLEN-1.
- Logic ops always process all NDIGITS, with fill applied above last.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE unless start is high. result and carry_out hold until the next accepted start.
- Latency: k processed digits give done k+1 cycles after the start edge. Minimum 2 cycles; maximum NDIGITS+1.
- start in RUN is ignored; no queueing.
- Reserved op codes execute as ADD.
- Inputs after the start edge do not affect the running operation.

Decomposition:
- serial_alu_pkg holds:
  - enum AluOp {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR}, 3 bits;
  - the state enum SeqState {IDLE, RUN, DONE};
  - function fill_digit(neg, is_sub).
- Sub-module digit_alu (combinational, parametrised by DIGIT_W) computes a, b', carry_in, op -> r, carry_out. The sequencer instantiates it once.

Test Plan:
1. ADD, word1 = 0x000000FF, word2 = 0x4, last = 0, neg = 0 -> 3 digits processed, result 0x00000103, carry_out 0, done 4 cycles after start.
2. ADD, word1 = 0x7B, word2 = 0xFFE (-2), last = 2, neg = 1 -> early exit after digit 2, result 0x00000079, carry_out 1, done at start+4.
3. SUB, word1 = 5, word2 = 7, last = 7 -> result 0xFFFFFFFE, carry_out 0, done at start+9, busy high for 8 cycles.
4. XOR, word1 = 0xA5A5A5A5, word2 = 0x0000FFFF with bits above digit 3 garbage (0x1234FFFF), last = 3, neg = 1 -> result 0x5A5A5A5A, carry_out 0, 8 digits processed.
5. Assert rst during RUN digit 2 of case 3 -> busy/done/result/carry_out = 0 without a clock edge; after release, repeat case 1 -> 0x00000103.
6. start pulsed in RUN -> ignored; start held in the DONE cycle -> new operation starts with no IDLE gap. Also run with XLEN = 16, DIGIT_W = 8: ADD 0x00FF + 0x01, last = 0 -> 0x0100, carry_out 0.
